resp_sig_collector: RTL and testbench
=====================================

// Module: resp_sig_collector
// PURPOSE
//  On-chip response-side counterpart of the LCG stimulus driver for fuzzed `top` instances.
//  - Samples the DUT's flat output vector every clock and compacts it into a MISR signature.
//  - Runs for a programmed number of cycles, after a fixed settle window, then holds the signature.
//  - Result is cross-simulator comparable without a per-cycle text log.
//  - Sits beside the DUT: resp_flat is wired to the DUT out_flat.
// PARAMETERS
//  OUT_W    159            width of resp_flat (DUT out_flat)
//  SIG_W    32             MISR / signature width
//  POLY     32'h04C11DB7   MISR feedback polynomial (SIG_W bits)
//  SEED     32'hFFFFFFFF   signature value at reset and on every start
//  SETTLE   2              cycles discarded after start before capture begins (>=0)
//  TRACE_D  8              trace buffer depth, power of 2; used only with RESP_TRACE_EN
// PORTS
//  clk         in   1                system clock, all state on posedge
//  rst_n       in   1                asynchronous active-low reset
//  start       in   1                1-cycle pulse; accepted only in IDLE or DONE
//  num_cycles  in   16               capture length; sampled on accepted start
//  resp_flat   in   OUT_W            DUT response vector, sampled every capture cycle
//  busy        out  1                high in SETTLE or CAPTURE
//  done        out  1                high in DONE, until the next accepted start
//  cyc_count   out  16               capture cycles completed so far
//  signature   out  SIG_W            current MISR value
//  trc_idx     in   $clog2(TRACE_D)  [RESP_TRACE_EN] trace read index, 0 = oldest
//  trc_data    out  SIG_W            [RESP_TRACE_EN] folded word at trc_idx; registered, 1-cycle latency
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; busy=0, done=0, cyc_count=0, signature=SEED; trace contents=0.
//   - Reset mid-run aborts with no partial done.
//  FSM states: IDLE, SETTLE, CAPTURE, DONE.
//   - IDLE/DONE --start--> SETTLE: latch num_cycles, signature<=SEED, cyc_count<=0, done<=0.
//   - SETTLE: counts SETTLE cycles. SETTLE=0 means SETTLE lasts 0 cycles; start goes directly to CAPTURE.
//   - SETTLE -> CAPTURE when the settle count is exhausted; if latched num_cycles==0, go to DONE instead.
//   - CAPTURE: each cycle signature<=misr(signature,fold(resp_flat)), cyc_count++.
//     Leave for DONE on the cycle that cyc_count reaches num_cycles.
//   - DONE: signature and cyc_count hold; done=1.
//  start while busy is ignored; no restart, no abort.
//  fold(): zero-pad resp_flat to a multiple of SIG_W, XOR all SIG_W slices (OUT_W=159 gives 5 slices).
//  misr(s,f) = {s[SIG_W-2:0],1'b0} ^ (s[SIG_W-1] ? POLY : 0) ^ f.
//  Latency: signature includes the word sampled at the last capture edge in the same cycle done rises.
//  cyc_count saturation: a 16-bit count cannot exceed num_cycles, so no wrap occurs.
// CONFIGURATION
//  RESP_TRACE_EN defined:
//   - Circular buffer of the last TRACE_D folded words, written during CAPTURE only.
//   - Write pointer wraps modulo TRACE_D; pointer clears on start.
//   - trc_idx is relative to the oldest valid entry.
//   - Entries not yet written since start read 0.
//  RESP_TRACE_EN undefined: no trc_* ports, no buffer storage.
// STRUCTURE
//  Package resp_sig_pkg holds:
//   - typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_DONE} rsc_state_t;
//   - default POLY/SEED localparams;
//   - function fold_vec.
//  One sub-module: resp_misr (SIG_W, POLY, SEED; ports clk, rst_n, clr, en, din, sig).
//  The FSM and trace buffer stay in the top.
// TESTING
//  1. start, num_cycles=0, SETTLE=2 -> done high 2 cycles after start;
//     signature=FFFFFFFF, cyc_count=0.
//  2. resp_flat=0, num_cycles=1 -> signature=FB3EE249, cyc_count=1.
//  3. resp_flat=1 (bit0 only), num_cycles=1 -> signature=FB3EE248.
//     Same result with only bit 128 set, which checks the fold.
//  4. start pulsed again mid-CAPTURE -> ignored; final cyc_count equals the original num_cycles.
//  5. rst_n low mid-CAPTURE -> busy=0, done=0, signature=FFFFFFFF immediately, asynchronously.
//  6. RESP_TRACE_EN, TRACE_D=8, 10 cycles of resp_flat=k (k=1..10) -> trc_idx 0..7 read folded 3..10.

Source files
------------

// File: rtl/resp_sig_pkg.sv
// Package: resp_sig_pkg
// Shared definitions for the response signature collector.
//  - rsc_state_t : collector FSM states
//  - RSC_DEF_POLY / RSC_DEF_SEED : default MISR polynomial and seed (32-bit)
//  - FOLD_MAX_W / FOLD_MAX_SIG : widest response vector / signature fold_vec handles
//  - fold_vec() : zero-padded XOR of all sig_w-bit slices of a response vector
package resp_sig_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_DONE} rsc_state_t;

  localparam logic [31:0] RSC_DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] RSC_DEF_SEED = 32'hFFFFFFFF;

  localparam int unsigned FOLD_MAX_W   = 512;
  localparam int unsigned FOLD_MAX_SIG = 64;

  // The caller zero-extends its vector to FOLD_MAX_W, so the padding of the
  // last partial slice is implicit. Only the low sig_w bits of the result
  // are meaningful.
  function automatic logic [FOLD_MAX_SIG-1:0] fold_vec(
    input logic [FOLD_MAX_W-1:0] v,
    input int unsigned           sig_w
  );
    logic [FOLD_MAX_SIG-1:0] r;
    logic [FOLD_MAX_SIG-1:0] mask;
    logic [FOLD_MAX_W-1:0]   t;
    r    = '0;
    t    = v;
    mask = (sig_w >= FOLD_MAX_SIG) ? '1 : ((64'd1 << sig_w) - 64'd1);
    for (int unsigned s = 0; s < FOLD_MAX_W; s += sig_w) begin
      r = r ^ (t[FOLD_MAX_SIG-1:0] & mask);
      t = t >> sig_w;
    end
    return r;
  endfunction

endpackage

// File: rtl/resp_misr.sv
// Module: resp_misr
// Multiple-input signature register used by resp_sig_collector.
// Ports:
//  clk   in   1      system clock
//  rst_n in   1      asynchronous active-low reset, loads SEED
//  clr   in   1      synchronous reload of SEED (takes priority over en)
//  en    in   1      advance the MISR by one step absorbing din
//  din   in   SIG_W  word absorbed on this step
//  sig   out  SIG_W  current signature
module resp_misr
  import resp_sig_pkg::*;
#(
  parameter int unsigned      SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(RSC_DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(RSC_DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  // Shift left, fold the bit shifted out back in through POLY, then absorb din.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (clr) begin
      sig <= SEED;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din;
    end
  end

endmodule

// File: rtl/resp_sig_collector.sv
// Module: resp_sig_collector
// Compacts a fuzzed DUT's flat output vector into a MISR signature over a
// programmed number of cycles, after a fixed settle window, then holds it.
// Optional feature macro: RESP_TRACE_EN (trace buffer of recent folded words).
// Ports:
//  clk        in   1                system clock
//  rst_n      in   1                asynchronous active-low reset
//  start      in   1                run request, accepted only in IDLE or DONE
//  num_cycles in   16               capture length, latched on accepted start
//  resp_flat  in   OUT_W            DUT response vector
//  busy       out  1                high in SETTLE or CAPTURE
//  done       out  1                high in DONE until the next accepted start
//  cyc_count  out  16               capture cycles completed
//  signature  out  SIG_W            current MISR value
//  trc_idx    in   $clog2(TRACE_D)  [RESP_TRACE_EN] read index, 0 = oldest entry
//  trc_data   out  SIG_W            [RESP_TRACE_EN] folded word, 1-cycle read latency
module resp_sig_collector
  import resp_sig_pkg::*;
#(
  parameter int unsigned      OUT_W   = 159,
  parameter int unsigned      SIG_W   = 32,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(RSC_DEF_POLY),
  parameter logic [SIG_W-1:0] SEED    = SIG_W'(RSC_DEF_SEED),
  parameter int unsigned      SETTLE  = 2,
  parameter int unsigned      TRACE_D = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      num_cycles,
  input  logic [OUT_W-1:0] resp_flat,
  output logic             busy,
  output logic             done,
  output logic [15:0]      cyc_count,
  output logic [SIG_W-1:0] signature
`ifdef RESP_TRACE_EN
  ,
  input  logic [$clog2(TRACE_D)-1:0] trc_idx,
  output logic [SIG_W-1:0]           trc_data
`endif
);

  localparam logic [15:0] SETTLE_LAST = (SETTLE > 0) ? 16'(SETTLE - 1) : 16'd0;

  rsc_state_t             state, next_state;
  logic [15:0]            num_lat;
  logic [15:0]            settle_cnt;
  logic                   start_ok;
  logic                   cap_en;
  logic [FOLD_MAX_W-1:0]  resp_pad;
  logic [SIG_W-1:0]       folded;

  assign resp_pad = FOLD_MAX_W'(resp_flat);
  assign folded   = SIG_W'(fold_vec(resp_pad, SIG_W));

  assign busy   = (state == ST_SETTLE) || (state == ST_CAPTURE);
  assign done   = (state == ST_DONE);
  assign cap_en = (state == ST_CAPTURE);

  // Next-state logic. A start seen while busy is simply not accepted.
  always_comb begin
    next_state = state;
    start_ok   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_ok = 1'b1;
          if (SETTLE == 0) begin
            next_state = (num_cycles == 16'd0) ? ST_DONE : ST_CAPTURE;
          end else begin
            next_state = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          next_state = (num_lat == 16'd0) ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // The capture edge that makes cyc_count reach num_lat is the last one.
        if (cyc_count + 16'd1 == num_lat) begin
          next_state = ST_DONE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State register and run counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      num_lat    <= '0;
      settle_cnt <= '0;
      cyc_count  <= '0;
    end else begin
      state <= next_state;
      if (start_ok) begin
        num_lat    <= num_cycles;
        settle_cnt <= '0;
        cyc_count  <= '0;
      end else if (state == ST_SETTLE) begin
        settle_cnt <= settle_cnt + 16'd1;
      end else if (cap_en) begin
        cyc_count <= cyc_count + 16'd1;
      end
    end
  end

  resp_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .en    (cap_en),
    .din   (folded),
    .sig   (signature)
  );

`ifdef RESP_TRACE_EN
  localparam int unsigned PW = $clog2(TRACE_D);

  logic [SIG_W-1:0] trc_mem [TRACE_D];
  logic [PW-1:0]    wr_ptr;
  logic             wrapped;
  logic [PW-1:0]    rd_addr;

  // Once the buffer has wrapped, the oldest entry sits at the write pointer.
  assign rd_addr = wrapped ? (wr_ptr + trc_idx) : trc_idx;

  // Circular trace buffer; cleared on start so unwritten entries read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(TRACE_D); i++) trc_mem[i] <= '0;
      wr_ptr   <= '0;
      wrapped  <= 1'b0;
      trc_data <= '0;
    end else begin
      trc_data <= trc_mem[rd_addr];
      if (start_ok) begin
        for (int i = 0; i < int'(TRACE_D); i++) trc_mem[i] <= '0;
        wr_ptr  <= '0;
        wrapped <= 1'b0;
      end else if (cap_en) begin
        trc_mem[wr_ptr] <= folded;
        wr_ptr          <= wr_ptr + 1'b1;
        if (wr_ptr == '1) wrapped <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_resp_sig_collector.sv
// Testbench: tb_resp_sig_collector
// Directed checks of resp_sig_collector with default parameters (SETTLE=2).
// Trace buffer checks are included when RESP_TRACE_EN is defined.
module tb_resp_sig_collector;

  localparam int OUT_W = 159;
  localparam int SIG_W = 32;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [15:0]      num_cycles;
  logic [OUT_W-1:0] resp_flat;
  logic             busy;
  logic             done;
  logic [15:0]      cyc_count;
  logic [SIG_W-1:0] signature;
`ifdef RESP_TRACE_EN
  logic [2:0]       trc_idx;
  logic [SIG_W-1:0] trc_data;
`endif

  int errors = 0;
  int checks = 0;

  resp_sig_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_cycles (num_cycles),
    .resp_flat  (resp_flat),
    .busy       (busy),
    .done       (done),
    .cyc_count  (cyc_count),
    .signature  (signature)
`ifdef RESP_TRACE_EN
    ,
    .trc_idx    (trc_idx),
    .trc_data   (trc_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [15:0] n, input logic [OUT_W-1:0] resp);
    @(negedge clk);
    num_cycles = n;
    resp_flat  = resp;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Bounded wait for done; an expired bound counts as a failed check.
  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    num_cycles = '0;
    resp_flat  = '0;
`ifdef RESP_TRACE_EN
    trc_idx    = '0;
`endif
    #12;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_cyc",  64'(cyc_count), 64'd0);
    checkOutput("reset_sig",  64'(signature), 64'hFFFFFFFF);
    @(negedge clk);
    rst_n = 1'b1;

    // num_cycles = 0: done two cycles after the start edge, seed untouched.
    applyStimulus(16'd0, '0);
    checkOutput("t1_busy_after_start", 64'(busy), 64'd1);
    checkOutput("t1_done_early0", 64'(done), 64'd0);
    @(negedge clk);
    checkOutput("t1_done_early1", 64'(done), 64'd0);
    @(negedge clk);
    checkOutput("t1_done", 64'(done), 64'd1);
    checkOutput("t1_busy", 64'(busy), 64'd0);
    checkOutput("t1_sig",  64'(signature), 64'hFFFFFFFF);
    checkOutput("t1_cyc",  64'(cyc_count), 64'd0);

    // One capture of an all-zero response.
    applyStimulus(16'd1, '0);
    checkOutput("t2_done_cleared", 64'(done), 64'd0);
    waitDone("t2_done");
    checkOutput("t2_sig", 64'(signature), 64'hFB3EE249);
    checkOutput("t2_cyc", 64'(cyc_count), 64'd1);

    // Bit 0 and bit 128 fold onto the same signature bit.
    applyStimulus(16'd1, OUT_W'(1));
    waitDone("t3a_done");
    checkOutput("t3a_sig", 64'(signature), 64'hFB3EE248);
    applyStimulus(16'd1, OUT_W'(1) << 128);
    waitDone("t3b_done");
    checkOutput("t3b_sig", 64'(signature), 64'hFB3EE248);

    // Two zero captures: second step feeds back through POLY.
    applyStimulus(16'd2, '0);
    waitDone("t3c_done");
    checkOutput("t3c_sig", 64'(signature), 64'hF2BCD925);
    checkOutput("t3c_cyc", 64'(cyc_count), 64'd2);

    // Start mid-capture is ignored.
    applyStimulus(16'd5, '0);
    repeat (3) @(negedge clk);
    num_cycles = 16'd3;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    checkOutput("t4_busy", 64'(busy), 64'd1);
    waitDone("t4_done");
    checkOutput("t4_cyc", 64'(cyc_count), 64'd5);
    repeat (2) @(negedge clk);
    checkOutput("t4_cyc_hold", 64'(cyc_count), 64'd5);
    checkOutput("t4_done_hold", 64'(done), 64'd1);

    // Asynchronous reset in the middle of a capture.
    applyStimulus(16'd10, OUT_W'(5));
    repeat (3) @(negedge clk);
    checkOutput("t5_busy_pre", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_busy", 64'(busy), 64'd0);
    checkOutput("t5_done", 64'(done), 64'd0);
    checkOutput("t5_sig",  64'(signature), 64'hFFFFFFFF);
    checkOutput("t5_cyc",  64'(cyc_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef RESP_TRACE_EN
    // Ten captures of k = 1..10; the last eight remain, oldest first.
    applyStimulus(16'd10, '0);
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      resp_flat = OUT_W'(k);
      @(negedge clk);
    end
    resp_flat = '0;
    waitDone("t6_done");
    for (int i = 0; i < 8; i++) begin
      trc_idx = 3'(i);
      @(negedge clk);
      checkOutput("t6_trc", 64'(trc_data), 64'(i + 3));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
